multibyte_compare_seq: RTL and testbench
========================================

Name: multibyte_compare_seq

Overview:
- Sequential magnitude comparator for operands of N_BYTES bytes, built around one shared 8-bit byte comparator.
- Walks the operands one byte per cycle, most significant byte first, and stops at the first byte that differs.
- Start/busy/done handshake to the ALU control path.
- Returns registered equal/greater/less flags plus the count of bytes examined.

Parameters:
- N_BYTES, 4, operand width in bytes; legal range is 1 and up.
- IDX_W, $clog2(N_BYTES) (minimum 1), width of the byte index register.
- CNT_W, $clog2(N_BYTES+1), width of bytes_used.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- cmp_signed  in  1  1 = two's-complement compare; sampled with start.
- a_in  in  8*N_BYTES  operand A; sampled with start.
- b_in  in  8*N_BYTES  operand B; sampled with start.
- busy  out  1  high while state is not IDLE.
- done  out  1  one-cycle pulse; result flags valid.
- equal  out  1  A == B.
- greater  out  1  A > B.
- less  out  1  A < B.
- bytes_used  out  CNT_W  number of bytes compared in the last operation.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; busy, done, equal, greater, less = 0; bytes_used = 0; internal operand registers and index = 0. Reset mid-operation aborts the operation; no done pulse is produced.
- States: IDLE, CMP, DONE.
- IDLE:
  - On a clock edge with start=1, latch a_in, b_in and cmp_signed; set idx = N_BYTES-1.
  - Clear equal, greater, less and bytes_used; go to CMP.
  - With start=0, hold state; previous results stay valid.
- CMP: each cycle compare byte idx of A against byte idx of B.
  - If cmp_signed=1 and idx = N_BYTES-1, invert bit 7 of both bytes before comparing. This is the sign-bias trick; lower bytes are always unsigned.
  - bytes_used increments by 1 on every CMP edge.
  - Bytes differ: set greater or less per the comparator; go to DONE.
  - Bytes equal and idx = 0: set equal=1; go to DONE.
  - Bytes equal and idx > 0: decrement idx; stay in CMP.
- DONE: done=1 for exactly this cycle; flags and bytes_used are valid; next edge goes to IDLE.
- Latency: with k = bytes compared (1..N_BYTES), done goes high k edges after the edge that sampled start.
  - Minimum throughput: one operation per k+2 cycles.
- Flag invariant: at most one of equal, greater, less is high.
  - Exactly one is high from done until the next accepted start.
  - All three are 0 while busy before the result is known.
- start while busy (CMP or DONE) is ignored, not queued.
  - start held high through DONE is accepted on the first IDLE edge.
- a_in, b_in and cmp_signed may change freely while busy; they have no effect.
- N_BYTES=1: single CMP cycle; the sign inversion applies to that byte.

Decomposition:
- Shared package alu_cmp_pkg:
  - state encoding constants (IDLE=2'd0, CMP=2'd1, DONE=2'd2);
  - the flag-vector ordering {greater, equal, less}.
- Sub-module: instantiate the existing byte_compare_behavioral once as the per-byte datapath.
  - Its inputs are the muxed, optionally bit-7-inverted bytes.
  - Its outputs feed the state-machine decision; no other comparison logic is allowed.
- Everything else (byte mux, index, counter, FSM, result registers) lives in multibyte_compare_seq.

Test Plan (N_BYTES=4):
1. Equal operands: a=0x12345678, b=0x12345678, unsigned. Required: done 4 edges after start, equal=1, greater=0, less=0, bytes_used=4.
2. Early exit on the top byte: a=0x80000000, b=0x7FFFFFFF, cmp_signed=0. Required: done 1 edge after start, greater=1, bytes_used=1. Repeat with cmp_signed=1. Required: less=1, bytes_used=1.
3. Difference in the LSB: a=0x12345600, b=0x12345601, unsigned. Required: less=1, bytes_used=4, done 4 edges after start. Swapped operands give greater=1.
4. Start held continuously with changing a_in/b_in while busy. Required: the first operation's result is unaffected; the second operation is accepted on the first IDLE edge after DONE; exactly one done pulse per operation.
5. Mid-operation reset: assert rst_n=0 two cycles into the case-1 compare. Required: all outputs 0 immediately (asynchronously), state IDLE, no done pulse. After release, case 3 completes correctly.
6. Signed negatives: a=0xFFFFFFFE (-2), b=0xFFFFFFFF (-1), cmp_signed=1. Required: less=1, bytes_used=4.

Source files
------------

// File: rtl/alu_cmp_pkg.sv
// Shared definitions for the ALU compare path: FSM state encoding and the
// {greater, equal, less} flag vector produced by the byte comparator.
package alu_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic greater;
    logic equal;
    logic less;
  } cmp_flags_t;

  localparam cmp_flags_t FLAGS_NONE  = '0;
  localparam cmp_flags_t FLAGS_EQUAL = '{greater: 1'b0, equal: 1'b1, less: 1'b0};

endpackage

// File: rtl/byte_compare_behavioral.sv
// Unsigned 8-bit magnitude comparator; exactly one output flag is high.
module byte_compare_behavioral
  import alu_cmp_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output cmp_flags_t flags
);

  always_comb begin
    flags         = FLAGS_NONE;
    flags.greater = (a > b);
    flags.equal   = (a == b);
    flags.less    = (a < b);
  end

endmodule

// File: rtl/multibyte_compare_seq.sv
// Sequential N-byte magnitude comparator: walks operands MSB-first through one
// shared byte comparator and stops at the first differing byte.
module multibyte_compare_seq
  import alu_cmp_pkg::*;
#(
  parameter int N_BYTES = 4,
  parameter int IDX_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1,
  parameter int CNT_W   = $clog2(N_BYTES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 cmp_signed,
  input  logic [8*N_BYTES-1:0] a_in,
  input  logic [8*N_BYTES-1:0] b_in,
  output logic                 busy,
  output logic                 done,
  output logic                 equal,
  output logic                 greater,
  output logic                 less,
  output logic [CNT_W-1:0]     bytes_used
);

  // Handshake: start is only sampled in IDLE (busy=0); start while busy is
  // dropped, not queued. done is a one-cycle pulse in DONE, and the flags plus
  // bytes_used stay valid from then until the next accepted start.

  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(N_BYTES - 1);

  state_t               state, state_d;
  logic [8*N_BYTES-1:0] a_q, b_q;
  logic                 sgn_q;
  logic [IDX_W-1:0]     idx;
  cmp_flags_t           res_q;
  cmp_flags_t           cmp;
  logic [7:0]           a_byte, b_byte;
  logic [7:0]           a_cmp, b_cmp;
  logic                 top_byte, last_byte, bias;

  assign top_byte  = (idx == TOP_IDX);
  assign last_byte = (idx == '0);
  // Flipping bit 7 of the top byte maps two's-complement order onto unsigned order.
  assign bias      = sgn_q && top_byte;

  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int i = 0; i < N_BYTES; i++) begin
      if (idx == IDX_W'(i)) begin
        a_byte = a_q[8*i +: 8];
        b_byte = b_q[8*i +: 8];
      end
    end
  end

  assign a_cmp = {a_byte[7] ^ bias, a_byte[6:0]};
  assign b_cmp = {b_byte[7] ^ bias, b_byte[6:0]};

  byte_compare_behavioral u_byte_cmp (
    .a     (a_cmp),
    .b     (b_cmp),
    .flags (cmp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = CMP;
      CMP:     if (!cmp.equal || last_byte) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      sgn_q      <= 1'b0;
      idx        <= '0;
      res_q      <= FLAGS_NONE;
      bytes_used <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q        <= a_in;
            b_q        <= b_in;
            sgn_q      <= cmp_signed;
            idx        <= TOP_IDX;
            res_q      <= FLAGS_NONE;
            bytes_used <= '0;
          end
        end
        CMP: begin
          bytes_used <= bytes_used + CNT_W'(1);
          if (!cmp.equal) begin
            res_q <= '{greater: cmp.greater, equal: 1'b0, less: cmp.less};
          end else if (last_byte) begin
            res_q <= FLAGS_EQUAL;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign greater = res_q.greater;
  assign equal   = res_q.equal;
  assign less    = res_q.less;

endmodule

// File: tb/tb_multibyte_compare_seq.sv
// Directed bench for multibyte_compare_seq with N_BYTES=4.
module tb_multibyte_compare_seq;

  localparam int N_BYTES = 4;
  localparam int CNT_W   = 3;
  localparam int MAX_LAT = 20;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic                 cmp_signed;
  logic [8*N_BYTES-1:0] a_in, b_in;
  logic                 busy, done, equal, greater, less;
  logic [CNT_W-1:0]     bytes_used;

  int n_checks = 0;
  int n_errors = 0;

  multibyte_compare_seq #(.N_BYTES(N_BYTES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cmp_signed (cmp_signed),
    .a_in       (a_in),
    .b_in       (b_in),
    .busy       (busy),
    .done       (done),
    .equal      (equal),
    .greater    (greater),
    .less       (less),
    .bytes_used (bytes_used)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launches one operation from IDLE and counts posedges until done (-1 on timeout).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < MAX_LAT) begin
      @(negedge clk);
      guard++;
    end
    a_in = a; b_in = b; cmp_signed = s; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int e = 1; e <= MAX_LAT; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = e;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; cmp_signed = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, equal, greater, less, bytes_used} !== 8'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b, expected 00000000",
               {busy, done, equal, greater, less, bytes_used});
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_equal();
    int lat;
    run_op(32'h12345678, 32'h12345678, 1'b0, lat);
    n_checks++;
    if (lat !== 4) begin n_errors++; $display("FAIL equal_latency: got %0d, expected 4", lat); end
    n_checks++;
    if ({greater, equal, less} !== 3'b010) begin
      n_errors++; $display("FAIL equal_flags: got %b, expected 010", {greater, equal, less});
    end
    n_checks++;
    if (bytes_used !== 3'd4) begin n_errors++; $display("FAIL equal_bytes: got %0d, expected 4", bytes_used); end
  endtask

  task automatic test_top_byte();
    int lat;
    run_op(32'h80000000, 32'h7FFFFFFF, 1'b0, lat);
    n_checks++;
    if (lat !== 1) begin n_errors++; $display("FAIL top_unsigned_latency: got %0d, expected 1", lat); end
    n_checks++;
    if ({greater, equal, less} !== 3'b100 || bytes_used !== 3'd1) begin
      n_errors++;
      $display("FAIL top_unsigned_result: got flags %b bytes %0d, expected 100 bytes 1",
               {greater, equal, less}, bytes_used);
    end
    run_op(32'h80000000, 32'h7FFFFFFF, 1'b1, lat);
    n_checks++;
    if (lat !== 1) begin n_errors++; $display("FAIL top_signed_latency: got %0d, expected 1", lat); end
    n_checks++;
    if ({greater, equal, less} !== 3'b001 || bytes_used !== 3'd1) begin
      n_errors++;
      $display("FAIL top_signed_result: got flags %b bytes %0d, expected 001 bytes 1",
               {greater, equal, less}, bytes_used);
    end
  endtask

  task automatic test_lsb_diff();
    int lat;
    run_op(32'h12345600, 32'h12345601, 1'b0, lat);
    n_checks++;
    if (lat !== 4) begin n_errors++; $display("FAIL lsb_latency: got %0d, expected 4", lat); end
    n_checks++;
    if ({greater, equal, less} !== 3'b001 || bytes_used !== 3'd4) begin
      n_errors++;
      $display("FAIL lsb_less: got flags %b bytes %0d, expected 001 bytes 4",
               {greater, equal, less}, bytes_used);
    end
    run_op(32'h12345601, 32'h12345600, 1'b0, lat);
    n_checks++;
    if (lat !== 4 || {greater, equal, less} !== 3'b100) begin
      n_errors++;
      $display("FAIL lsb_greater: got lat %0d flags %b, expected lat 4 flags 100",
               lat, {greater, equal, less});
    end
  endtask

  // start stays high across both operations; inputs are scrambled while busy.
  task automatic test_back_to_back();
    int done_cnt;
    int done_edge[$];
    logic [2:0] flags_at[$];
    logic [CNT_W-1:0] bytes_at[$];
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < MAX_LAT) begin @(negedge clk); guard++; end
    a_in = 32'hAA000000; b_in = 32'h55000000; cmp_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    done_cnt = 0;
    for (int e = 1; e <= 12; e++) begin
      #1;
      if (e == 1) begin a_in = 32'h00000001; b_in = 32'h00000002; end
      if (e == 4) begin a_in = 32'hFFFFFFFF; b_in = 32'h00000000; cmp_signed = 1'b1; end
      if (e == 5) start = 1'b0;
      @(posedge clk);
      #1;
      if (done) begin
        done_cnt++;
        done_edge.push_back(e);
        flags_at.push_back({greater, equal, less});
        bytes_at.push_back(bytes_used);
      end
    end
    n_checks++;
    if (done_cnt !== 2) begin
      n_errors++; $display("FAIL b2b_done_count: got %0d, expected 2", done_cnt);
    end else begin
      n_checks++;
      if (done_edge[0] !== 1 || flags_at[0] !== 3'b100 || bytes_at[0] !== 3'd1) begin
        n_errors++;
        $display("FAIL b2b_first: got edge %0d flags %b bytes %0d, expected edge 1 flags 100 bytes 1",
                 done_edge[0], flags_at[0], bytes_at[0]);
      end
      n_checks++;
      if (done_edge[1] !== 7 || flags_at[1] !== 3'b001 || bytes_at[1] !== 3'd4) begin
        n_errors++;
        $display("FAIL b2b_second: got edge %0d flags %b bytes %0d, expected edge 7 flags 001 bytes 4",
                 done_edge[1], flags_at[1], bytes_at[1]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    int seen_done;
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < MAX_LAT) begin @(negedge clk); guard++; end
    a_in = 32'h12345678; b_in = 32'h12345678; cmp_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if ({busy, done, greater, equal, less} !== 5'b10000 || bytes_used !== 3'd2) begin
      n_errors++;
      $display("FAIL midop_in_progress: got busy/done/gel %b bytes %0d, expected 10000 bytes 2",
               {busy, done, greater, equal, less}, bytes_used);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, equal, greater, less, bytes_used} !== 8'b0) begin
      n_errors++;
      $display("FAIL midop_async_clear: got %b, expected 00000000",
               {busy, done, equal, greater, less, bytes_used});
    end
    seen_done = 0;
    repeat (3) begin
      @(posedge clk);
      #1 if (done) seen_done++;
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1 if (done) seen_done++;
    end
    n_checks++;
    if (seen_done !== 0) begin n_errors++; $display("FAIL midop_no_done: got %0d pulses, expected 0", seen_done); end
    run_op(32'h12345600, 32'h12345601, 1'b0, lat);
    n_checks++;
    if (lat !== 4 || {greater, equal, less} !== 3'b001 || bytes_used !== 3'd4) begin
      n_errors++;
      $display("FAIL midop_recover: got lat %0d flags %b bytes %0d, expected lat 4 flags 001 bytes 4",
               lat, {greater, equal, less}, bytes_used);
    end
  endtask

  task automatic test_signed_negatives();
    int lat;
    run_op(32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, lat);
    n_checks++;
    if (lat !== 4 || {greater, equal, less} !== 3'b001 || bytes_used !== 3'd4) begin
      n_errors++;
      $display("FAIL signed_neg: got lat %0d flags %b bytes %0d, expected lat 4 flags 001 bytes 4",
               lat, {greater, equal, less}, bytes_used);
    end
    run_op(32'h00000005, 32'hFFFFFFFB, 1'b1, lat);
    n_checks++;
    if (lat !== 1 || {greater, equal, less} !== 3'b100 || bytes_used !== 3'd1) begin
      n_errors++;
      $display("FAIL signed_pos_vs_neg: got lat %0d flags %b bytes %0d, expected lat 1 flags 100 bytes 1",
               lat, {greater, equal, less}, bytes_used);
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_top_byte();
    test_lsb_diff();
    test_back_to_back();
    test_mid_reset();
    test_signed_negatives();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
